// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage MIPS core.
// Handles the hazards that forwarding cannot cover:
//   - load-use stalls,
//   - taken-branch squashes,
//   - multi-cycle mul/div occupancy of EX,
//   - external (exception) flushes.
// It drives the PC, IF/ID, ID/EX and EX/MEM control strobes.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   When defined, Stall_Cycles counts cycles with PC_Write=0 and saturates
//   at 16'hFFFF. When undefined, Stall_Cycles is tied to zero.
//
// Parameters:
//   MD_CYCLES  total cycles a mul/div occupies EX (2..15)
//   CNT_W      busy counter width, must hold MD_CYCLES-1
//
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   ID_RegisterRs/Rt, ID_UsesRt     source operands of the ID instruction
//   EX_MemRead, EX_Write_register   load detection for the EX instruction
//   EX_MdStart                      first EX cycle of a mul/div
//   EX_BranchTaken                  branch/jump resolved taken in EX
//   Flush_req                       exception flush request
//   PC_Write, IFID_Write            pipeline advance enables
//   IFID_Flush, IDEX_Flush          squash / bubble strobes
//   EXMEM_Bubble, EX_Hold           EX occupancy control
//   MD_Busy, MD_Done                mul/div status
//   Stall_Cycles                    optional stall performance counter
module hazard_ctrl #(
  parameter int unsigned MD_CYCLES = 8,
  parameter int unsigned CNT_W     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ID_RegisterRs,
  input  logic [4:0]  ID_RegisterRt,
  input  logic        ID_UsesRt,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_Write_register,
  input  logic        EX_MdStart,
  input  logic        EX_BranchTaken,
  input  logic        Flush_req,
  output logic        PC_Write,
  output logic        IFID_Write,
  output logic        IFID_Flush,
  output logic        IDEX_Flush,
  output logic        EXMEM_Bubble,
  output logic        EX_Hold,
  output logic        MD_Busy,
  output logic        MD_Done,
  output logic [15:0] Stall_Cycles
);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             load_use;

  assign load_use = EX_MemRead && (EX_Write_register != 5'd0) &&
                    ((EX_Write_register == ID_RegisterRs) ||
                     (ID_UsesRt && (EX_Write_register == ID_RegisterRt)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    PC_Write     = 1'b1;
    IFID_Write   = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Flush   = 1'b0;
    EXMEM_Bubble = 1'b0;
    EX_Hold      = 1'b0;
    MD_Busy      = 1'b0;
    MD_Done      = 1'b0;

    case (state)
      RUN: begin
        if (Flush_req) begin
          IFID_Flush   = 1'b1;
          IDEX_Flush   = 1'b1;
          EXMEM_Bubble = 1'b1;
        end else if (EX_BranchTaken) begin
          IFID_Flush = 1'b1;
          IDEX_Flush = 1'b1;
        end else if (EX_MdStart) begin
          PC_Write     = 1'b0;
          IFID_Write   = 1'b0;
          EX_Hold      = 1'b1;
          EXMEM_Bubble = 1'b1;
          cnt_next     = MD_LOAD;
          state_next   = MD_BUSY;
        end else if (load_use) begin
          PC_Write   = 1'b0;
          IFID_Write = 1'b0;
          IDEX_Flush = 1'b1;
        end
      end

      MD_BUSY: begin
        MD_Busy = 1'b1;
        if (Flush_req) begin
          IFID_Flush   = 1'b1;
          IDEX_Flush   = 1'b1;
          EXMEM_Bubble = 1'b1;
          cnt_next     = '0;
          state_next   = RUN;
        end else if (cnt > ONE) begin
          PC_Write     = 1'b0;
          IFID_Write   = 1'b0;
          EX_Hold      = 1'b1;
          EXMEM_Bubble = 1'b1;
          cnt_next     = cnt - ONE;
        end else begin
          // cnt==1 is the release cycle; cnt==0 cannot occur here but is
          // treated the same so the FSM can never get stuck in MD_BUSY.
          MD_Done    = 1'b1;
          cnt_next   = '0;
          state_next = RUN;
        end
      end

      default: begin
        cnt_next   = '0;
        state_next = RUN;
      end
    endcase

    // Reset forces the strobes without waiting for a clock edge.
    if (!rst_n) begin
      PC_Write     = 1'b0;
      IFID_Write   = 1'b0;
      IFID_Flush   = 1'b1;
      IDEX_Flush   = 1'b1;
      EXMEM_Bubble = 1'b1;
      EX_Hold      = 1'b0;
      MD_Busy      = 1'b0;
      MD_Done      = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!PC_Write && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign Stall_Cycles = stall_cnt;
`else
  assign Stall_Cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed, table-driven bench for hazard_ctrl.
// A vector table covers the single-cycle RUN-state decisions. Hand-written
// sequences cover the multi-cycle cases: mul/div occupancy (MD_CYCLES=8 and
// MD_CYCLES=2), flush abort of MD_BUSY, and reset asserted mid-MD_BUSY.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ID_RegisterRs, ID_RegisterRt, EX_Write_register;
  logic        ID_UsesRt, EX_MemRead, EX_MdStart, EX_BranchTaken, Flush_req;
  logic        PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Bubble;
  logic        EX_Hold, MD_Busy, MD_Done;
  logic [15:0] Stall_Cycles;

  logic        PC_Write2, IFID_Write2, IFID_Flush2, IDEX_Flush2, EXMEM_Bubble2;
  logic        EX_Hold2, MD_Busy2, MD_Done2;
  logic [15:0] Stall_Cycles2;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.MD_CYCLES(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_RegisterRs(ID_RegisterRs), .ID_RegisterRt(ID_RegisterRt),
    .ID_UsesRt(ID_UsesRt), .EX_MemRead(EX_MemRead),
    .EX_Write_register(EX_Write_register), .EX_MdStart(EX_MdStart),
    .EX_BranchTaken(EX_BranchTaken), .Flush_req(Flush_req),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Flush(IDEX_Flush), .EXMEM_Bubble(EXMEM_Bubble), .EX_Hold(EX_Hold),
    .MD_Busy(MD_Busy), .MD_Done(MD_Done), .Stall_Cycles(Stall_Cycles)
  );

  hazard_ctrl #(.MD_CYCLES(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .ID_RegisterRs(ID_RegisterRs), .ID_RegisterRt(ID_RegisterRt),
    .ID_UsesRt(ID_UsesRt), .EX_MemRead(EX_MemRead),
    .EX_Write_register(EX_Write_register), .EX_MdStart(EX_MdStart),
    .EX_BranchTaken(EX_BranchTaken), .Flush_req(Flush_req),
    .PC_Write(PC_Write2), .IFID_Write(IFID_Write2), .IFID_Flush(IFID_Flush2),
    .IDEX_Flush(IDEX_Flush2), .EXMEM_Bubble(EXMEM_Bubble2), .EX_Hold(EX_Hold2),
    .MD_Busy(MD_Busy2), .MD_Done(MD_Done2), .Stall_Cycles(Stall_Cycles2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe bundle order: {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Bubble, EX_Hold}
  localparam logic [5:0] S_DEF   = 6'b110000;
  localparam logic [5:0] S_LU    = 6'b000100;
  localparam logic [5:0] S_BR    = 6'b111100;
  localparam logic [5:0] S_FL    = 6'b111110;
  localparam logic [5:0] S_HOLD  = 6'b000011;
  localparam logic [5:0] S_RESET = 6'b001110;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [15:0] STALL_MD = 16'd7;
  localparam logic [15:0] STALL_C4 = 16'd3;
`else
  localparam logic [15:0] STALL_MD = 16'd0;
  localparam logic [15:0] STALL_C4 = 16'd0;
`endif

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       memread;
    logic [4:0] wr;
    logic       mdstart;
    logic       br;
    logic       flush;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [5:0] strobes();
    return {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Bubble, EX_Hold};
  endfunction

  function automatic logic [5:0] strobes2();
    return {PC_Write2, IFID_Write2, IFID_Flush2, IDEX_Flush2, EXMEM_Bubble2, EX_Hold2};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic idle();
    ID_RegisterRs     = 5'd0;
    ID_RegisterRt     = 5'd0;
    ID_UsesRt         = 1'b0;
    EX_MemRead        = 1'b0;
    EX_Write_register = 5'd0;
    EX_MdStart        = 1'b0;
    EX_BranchTaken    = 1'b0;
    Flush_req         = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // rs rt uses memread wr md br fl expected
    vecs[0] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, S_DEF}; // idle
    vecs[1] = '{5'd8, 5'd1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, S_LU};  // load-use on rs
    vecs[2] = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, S_DEF}; // $zero never stalls
    vecs[3] = '{5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, S_DEF}; // rt not used
    vecs[4] = '{5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, S_LU};  // rt used
    vecs[5] = '{5'd8, 5'd8, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, S_DEF}; // not a load
    vecs[6] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, S_BR};  // branch
    vecs[7] = '{5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, S_BR};  // branch > md > load-use
    vecs[8] = '{5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b1, S_FL};  // flush wins all
    vecs[9] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, S_FL};  // flush alone

    // Reset state
    idle();
    rst_n = 1'b0;
    #1;
    chk("reset_strobes", 16'(strobes()), 16'(S_RESET));
    chk("reset_busy", 16'(MD_Busy), 16'd0);
    chk("reset_done", 16'(MD_Done), 16'd0);
    chk("reset_stall", Stall_Cycles, 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset_strobes", 16'(strobes()), 16'(S_DEF));

    // Single-cycle RUN decisions; the next cycle must be back to defaults
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ID_RegisterRs     = vecs[i].rs;
      ID_RegisterRt     = vecs[i].rt;
      ID_UsesRt         = vecs[i].uses_rt;
      EX_MemRead        = vecs[i].memread;
      EX_Write_register = vecs[i].wr;
      EX_MdStart        = vecs[i].mdstart;
      EX_BranchTaken    = vecs[i].br;
      Flush_req         = vecs[i].flush;
      #1;
      chk($sformatf("vec%0d_strobes", i), 16'(strobes()), 16'(vecs[i].exp));
      chk($sformatf("vec%0d_busy", i), 16'(MD_Busy), 16'd0);
      @(negedge clk);
      idle();
      #1;
      chk($sformatf("vec%0d_next_strobes", i), 16'(strobes()), 16'(S_DEF));
      chk($sformatf("vec%0d_next_busy", i), 16'(MD_Busy), 16'd0);
    end

    // Mul/div, MD_CYCLES=8; branch and load-use injected while busy are ignored
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      if (c > 1) @(negedge clk);
      idle();
      EX_MdStart = (c == 1);
      EX_BranchTaken = (c == 3);
      if (c == 4) begin
        EX_MemRead = 1'b1; EX_Write_register = 5'd8; ID_RegisterRs = 5'd8;
      end
      #1;
      chk($sformatf("md_c%0d_strobes", c), 16'(strobes()),
          16'((c <= 7) ? S_HOLD : S_DEF));
      chk($sformatf("md_c%0d_busy", c), 16'(MD_Busy), 16'((c >= 2 && c <= 8) ? 1 : 0));
      chk($sformatf("md_c%0d_done", c), 16'(MD_Done), 16'((c == 8) ? 1 : 0));
      if (c == 4) chk("md_c4_stall", Stall_Cycles, STALL_C4);
      if (c >= 8) chk($sformatf("md_c%0d_stall", c), Stall_Cycles, STALL_MD);
    end

    // Mul/div, MD_CYCLES=2: start cycle then straight into release
    do_reset();
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) @(negedge clk);
      idle();
      EX_MdStart = (c == 1);
      #1;
      chk($sformatf("md2_c%0d_strobes", c), 16'(strobes2()), 16'((c == 1) ? S_HOLD : S_DEF));
      chk($sformatf("md2_c%0d_busy", c), 16'(MD_Busy2), 16'((c == 2) ? 1 : 0));
      chk($sformatf("md2_c%0d_done", c), 16'(MD_Done2), 16'((c == 2) ? 1 : 0));
    end

    // Flush abort in cycle 4 of the mul/div; MD_Done must never fire
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) @(negedge clk);
      idle();
      EX_MdStart = (c == 1);
      Flush_req  = (c == 4);
      #1;
      chk($sformatf("ab_c%0d_strobes", c), 16'(strobes()),
          16'((c <= 3) ? S_HOLD : (c == 4) ? S_FL : S_DEF));
      chk($sformatf("ab_c%0d_busy", c), 16'(MD_Busy), 16'((c >= 2 && c <= 4) ? 1 : 0));
      chk($sformatf("ab_c%0d_done", c), 16'(MD_Done), 16'd0);
    end

    // Reset asserted mid-cycle in cycle 3 of the mul/div
    do_reset();
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) @(negedge clk);
      idle();
      EX_MdStart = (c == 1);
      #1;
      chk($sformatf("rs_c%0d_strobes", c), 16'(strobes()), 16'(S_HOLD));
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk("rs_async_strobes", 16'(strobes()), 16'(S_RESET));
    chk("rs_async_busy", 16'(MD_Busy), 16'd0);
    chk("rs_async_stall", Stall_Cycles, 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rs_release_strobes", 16'(strobes()), 16'(S_DEF));
    chk("rs_release_busy", 16'(MD_Busy), 16'd0);
    @(negedge clk);
    #1;
    chk("rs_after_strobes", 16'(strobes()), 16'(S_DEF));
    chk("rs_after_busy", 16'(MD_Busy), 16'd0);
    chk("rs_after_done", 16'(MD_Done), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
